// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-fed UART transmitter with compile-time frame format.
// Pops one word from the source FIFO per frame and serialises it as
// start bit, DATA_BITS data bits (LSB first), optional parity and stop bits.
// A word waiting at the end of the last stop bit is sent back-to-back.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    input  logic [DATA_BITS-1:0] data,
    output logic                 start,
    output logic                 uart,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a data word: odd mode makes total ones odd, even mode even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic p;
        case (PARITY)
            32'sd1:  p = ~(^d);
            32'sd2:  p = ^d;
            default: p = 1'b1;
        endcase
        return p;
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] frame_q, frame_d;
    logic                 par_q, par_d;
    logic                 uart_q, uart_d;
    logic                 busy_q, busy_d;
    logic                 rst_dly_q, rst_dly_d;
    logic                 bit_end_s;
    logic                 last_stop_s;
    logic                 start_s;

    // Pop decision: idle, or final cycle of final stop bit, never during or right after reset.
    always_comb begin
        bit_end_s   = (cnt_q == CNT_LAST);
        last_stop_s = (state_q == ST_STOP) && bit_end_s && (idx_q == STOP_LAST);
        start_s     = !empty && !rst && !rst_dly_q &&
                      ((state_q == ST_IDLE) || last_stop_s);
        rst_dly_d   = rst;
    end

    // Next-state logic for the frame sequencer, counters and frame shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    frame_d = data;
                    par_d   = parity_bit(data);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 32'sd0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        frame_d = {1'b1, frame_q[DATA_BITS-1:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        if (start_s) begin
                            state_d = ST_START;
                            frame_d = data;
                            par_d   = parity_bit(data);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Line level and busy flag derived from the next state so both come out of flops.
    always_comb begin
        case (state_d)
            ST_START:  uart_d = 1'b0;
            ST_DATA:   uart_d = frame_d[0];
            ST_PARITY: uart_d = par_d;
            default:   uart_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset to an idle, line-high state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '1;
            par_q     <= 1'b1;
            uart_q    <= 1'b1;
            busy_q    <= 1'b0;
            rst_dly_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            par_q     <= par_d;
            uart_q    <= uart_d;
            busy_q    <= busy_d;
            rst_dly_q <= rst_dly_d;
        end
    end

    assign start = start_s;
    assign uart  = uart_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: four instances cover 8N1, 8E1, 8O1 and 7N2 at
// four clocks per bit; frames are compared bit by bit against a vector table.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic       empty0, empty1, empty2, empty3;
    logic [7:0] data0, data1, data2;
    logic [6:0] data3;
    logic       start0, start1, start2, start3;
    logic       uart0, uart1, uart2, uart3;
    logic       busy0, busy1, busy2, busy3;
    logic       start_m, uart_m, busy_m;
    int         sel;
    int         checks;
    int         errors;

    typedef struct {
        int          sel;
        logic [8:0]  d;
        logic [11:0] exp;
        int          nbits;
    } vec_t;

    vec_t tbl[14];

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .empty(empty0), .data(data0),
        .start(start0), .uart(uart0), .busy(busy0));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .empty(empty1), .data(data1),
        .start(start1), .uart(uart1), .busy(busy1));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .empty(empty2), .data(data2),
        .start(start2), .uart(uart2), .busy(busy2));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .empty(empty3), .data(data3),
        .start(start3), .uart(uart3), .busy(busy3));

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance's outputs to the common check signals.
    always_comb begin
        case (sel)
            1:       begin start_m = start1; uart_m = uart1; busy_m = busy1; end
            2:       begin start_m = start2; uart_m = uart2; busy_m = busy2; end
            3:       begin start_m = start3; uart_m = uart3; busy_m = busy3; end
            default: begin start_m = start0; uart_m = uart0; busy_m = busy0; end
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", nm, sel, act, exp, $time);
        end
    endtask

    task automatic set_src(input int s, input logic e, input logic [8:0] d);
        case (s)
            1:       begin empty1 = e; data1 = d[7:0]; end
            2:       begin empty2 = e; data2 = d[7:0]; end
            3:       begin empty3 = e; data3 = d[6:0]; end
            default: begin empty0 = e; data0 = d[7:0]; end
        endcase
    endtask

    // Offer a word at a negedge, expect the pop strobe, then pass the capture edge.
    task automatic launch(input logic [8:0] d);
        @(negedge clk);
        set_src(sel, 1'b0, d);
        #1;
        chk("start_pulse", {31'd0, start_m}, 32'd1);
        @(posedge clk);
    endtask

    // Check a whole frame from the first start-bit cycle, then the return to idle.
    task automatic frame_body(input logic [11:0] exp, input int nbits, input logic [8:0] d);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) set_src(sel, 1'b1, ~d);
                #1;
                chk("uart_bit", {31'd0, uart_m}, {31'd0, exp[b]});
                chk("busy_frame", {31'd0, busy_m}, 32'd1);
                chk("start_quiet", {31'd0, start_m}, 32'd0);
            end
        end
        @(negedge clk);
        #1;
        chk("idle_uart", {31'd0, uart_m}, 32'd1);
        chk("idle_busy", {31'd0, busy_m}, 32'd0);
    endtask

    localparam logic [11:0] EXP_A5 = 12'b00_1_10100101_0;
    localparam logic [11:0] EXP_3C = 12'b00_1_00111100_0;

    initial begin
        checks = 0;
        errors = 0;
        sel    = 0;
        rst    = 1'b1;
        empty0 = 1'b1; empty1 = 1'b1; empty2 = 1'b1; empty3 = 1'b1;
        data0  = 8'h00; data1 = 8'h00; data2 = 8'h00; data3 = 7'h00;

        tbl[0]  = '{0, 9'h0A5, 12'b00_1_10100101_0, 10};
        tbl[1]  = '{0, 9'h000, 12'b00_1_00000000_0, 10};
        tbl[2]  = '{0, 9'h0FF, 12'b00_1_11111111_0, 10};
        tbl[3]  = '{0, 9'h001, 12'b00_1_00000001_0, 10};
        tbl[4]  = '{0, 9'h080, 12'b00_1_10000000_0, 10};
        tbl[5]  = '{1, 9'h003, 12'b0_1_0_00000011_0, 11};
        tbl[6]  = '{1, 9'h007, 12'b0_1_1_00000111_0, 11};
        tbl[7]  = '{1, 9'h000, 12'b0_1_0_00000000_0, 11};
        tbl[8]  = '{2, 9'h003, 12'b0_1_1_00000011_0, 11};
        tbl[9]  = '{2, 9'h007, 12'b0_1_0_00000111_0, 11};
        tbl[10] = '{2, 9'h000, 12'b0_1_1_00000000_0, 11};
        tbl[11] = '{3, 9'h0FF, 12'b00_11_1111111_0, 10};
        tbl[12] = '{3, 9'h02A, 12'b00_11_0101010_0, 10};
        tbl[13] = '{3, 9'h080, 12'b00_11_0000000_0, 10};

        // Reset state with a word already waiting on instance 0.
        repeat (3) @(negedge clk);
        set_src(0, 1'b0, 9'h0A5);
        #1;
        chk("rst_start", {28'd0, start0, start1, start2, start3}, 32'd0);
        chk("rst_uart", {28'd0, uart0, uart1, uart2, uart3}, 32'hF);
        chk("rst_busy", {28'd0, busy0, busy1, busy2, busy3}, 32'd0);

        // No pop in the cycle reset drops; pop one cycle later.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("start_rst_release", {31'd0, start_m}, 32'd0);
        @(negedge clk);
        #1;
        chk("start_after_release", {31'd0, start_m}, 32'd1);
        @(posedge clk);
        frame_body(EXP_A5, 10, 9'h0A5);

        // Table of single frames across all four formats.
        for (int i = 0; i < 14; i++) begin
            sel = tbl[i].sel;
            launch(tbl[i].d);
            frame_body(tbl[i].exp, tbl[i].nbits, tbl[i].d);
        end

        // Back-to-back: two words queued, pops exactly 40 cycles apart, no idle gap.
        sel = 0;
        launch(9'h0A5);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) set_src(0, 1'b0, 9'h03C);
            #1;
            chk("b2b_uart", {31'd0, uart_m}, {31'd0, EXP_A5[(c - 1) / 4]});
            chk("b2b_busy", {31'd0, busy_m}, 32'd1);
            chk("b2b_start", {31'd0, start_m}, (c == 40) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        frame_body(EXP_3C, 10, 9'h03C);

        // Reset during data bit 3 aborts the frame; a fresh frame follows.
        launch(9'h0A5);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            #1;
            chk("pre_abort_uart", {31'd0, uart_m}, {31'd0, EXP_A5[(c - 1) / 4]});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("start_in_rst", {31'd0, start_m}, 32'd0);
        @(negedge clk);
        #1;
        chk("abort_uart", {31'd0, uart_m}, 32'd1);
        chk("abort_busy", {31'd0, busy_m}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_release_start", {31'd0, start_m}, 32'd0);
        @(negedge clk);
        #1;
        chk("abort_restart", {31'd0, start_m}, 32'd1);
        @(posedge clk);
        frame_body(EXP_A5, 10, 9'h0A5);

        // Long empty stretch: nothing pops, line idle, not busy.
        set_src(0, 1'b1, 9'h0A5);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            #1;
            chk("empty_start", {28'd0, start0, start1, start2, start3}, 32'd0);
            chk("empty_uart", {28'd0, uart0, uart1, uart2, uart3}, 32'hF);
            chk("empty_busy", {28'd0, busy0, busy1, busy2, busy3}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port empty, input, 1 bit: source FIFO empty flag; 0 = a word is available.
REQ-009 SHALL have port data, input, DATA_BITS bits: source FIFO head word.
REQ-010 SHALL have port start, output, 1 bit: one-cycle pop strobe to the source FIFO; data is captured in this cycle.
REQ-011 SHALL have port uart, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is on the line.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL assert start for exactly one cycle when empty=0 and either (a) state=IDLE or (b) state=STOP in the last cycle of the last stop bit; start SHALL never assert in any other cycle.
REQ-015 SHALL capture data into a frame register in the start cycle and ignore later changes on data.
REQ-016 SHALL drive uart=0 (start bit) from the cycle after start for CLKS_PER_BIT cycles.
REQ-017 SHALL then send DATA_BITS data bits, LSB first, each for CLKS_PER_BIT cycles.
REQ-018 SHALL, when PARITY=1, send one parity bit making the ones count of data+parity odd; when PARITY=2, make it even; when PARITY=0, skip the PARITY state.
REQ-019 SHALL send STOP_BITS stop bits (uart=1), each for CLKS_PER_BIT cycles.
REQ-020 SHALL give a frame length of F=(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-021 SHALL, on a start per REQ-014(b), begin the next start bit directly after the last stop-bit cycle, with no idle gap; back-to-back start pulses SHALL be exactly F cycles apart.
REQ-022 SHALL otherwise go from the last stop-bit cycle to IDLE with uart=1.
REQ-023 SHALL drive busy=1 from the cycle after start through the last stop-bit cycle; busy SHALL stay 1 across back-to-back frames.
REQ-024 SHALL drive uart=1 in IDLE.
REQ-025 SHALL ignore empty changes during a frame; only the sample in the REQ-014 cycles counts.
REQ-026 SHALL keep its bit-time counter width at ceil(log2(CLKS_PER_BIT)) bits and its bit-index counter width at ceil(log2(DATA_BITS+1)) bits; no counter SHALL wrap within a bit or frame.
REQ-027 SHALL register uart with no combinational path from inputs; start MAY depend combinationally on empty.

Reset
REQ-028 SHALL, while rst=1, hold state=IDLE, uart=1, busy=0, start=0, counters at 0, and frame register at all ones.
REQ-029 SHALL, on rst asserted mid-frame, abort the frame so uart=1 and busy=0 in the cycle after the reset edge, with no pop.
REQ-030 SHALL not assert start in the cycle rst deasserts; the first start can occur one cycle later if empty=0.

Verification
REQ-031 SHALL be checked with CLKS_PER_BIT=4, 8N1 and data=0xA5 -> one start pulse, then uart = 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; busy high for 40 cycles.
REQ-032 SHALL be checked with PARITY=2 and data=0x03, then PARITY=1 and data=0x03 -> parity bit 0 for the even case and 1 for the odd case; frame 44 cycles at CLKS_PER_BIT=4.
REQ-033 SHALL be checked with two words queued (empty=0 continuously) at CLKS_PER_BIT=4, 8N1 -> start pulses exactly 40 cycles apart, uart never high between the stop bit and the second start bit, busy continuously 1.
REQ-034 SHALL be checked with DATA_BITS=7, STOP_BITS=2 and data=0x7F -> uart = 0, seven 1s, 1, 1; frame 10*CLKS_PER_BIT cycles; bit 7 of the source not present.
REQ-035 SHALL be checked with rst pulsed during data bit 3 -> uart=1 and busy=0 the next cycle; no start in the rst-deassert cycle; with empty=0 a fresh full frame follows.
REQ-036 SHALL be checked with empty held 1 for 1000 cycles -> start never asserts, uart constantly 1, busy 0.
